// File: rtl/e_delay_arbiter.sv
// e_delay_arbiter
//
// Round-robin arbiter that shares one DEPTH-stage extract-and-delay pipeline
// between N requesters. Each cycle at most one requester is granted. The top
// 4-bit field of its word goes down the pipeline, tagged with the requester
// index, and comes out on a single valid/ready result port.
//
// Parameters:
//   N      number of requesters (2..8)
//   W      request word width (>= 4); the field is bits [W-1:W-4]
//   DEPTH  pipeline stages (>= 1)
//
// Ports:
//   _i_clk        clock, rising edge
//   _i_rst_n      asynchronous active-low reset
//   _i_req_valid  per-requester valid
//   _i_req_data   packed request words, requester i at [i*W +: W]
//   _o_req_ready  one-hot grant (or zero); combinational
//   _o_valid      result valid (stage DEPTH)
//   _o_result     extracted 4-bit field
//   _o_tag        index of the originating requester
//   _i_ready      downstream accepts the result
//   _o_stats      per-requester saturating completion counters, [i*8 +: 8]
//                 (only when DELAY_ARB_STATS_EN is defined)
//
// Optional feature macro: DELAY_ARB_STATS_EN
module e_delay_arbiter #(
  parameter int unsigned N     = 4,
  parameter int unsigned W     = 16,
  parameter int unsigned DEPTH = 3,
  localparam int unsigned TW   = (N > 1) ? $clog2(N) : 1
) (
  input  logic             _i_clk,
  input  logic             _i_rst_n,
  input  logic [N-1:0]     _i_req_valid,
  input  logic [N*W-1:0]   _i_req_data,
  output logic [N-1:0]     _o_req_ready,
  output logic             _o_valid,
  output logic [3:0]       _o_result,
  output logic [TW-1:0]    _o_tag,
  input  logic             _i_ready
`ifdef DELAY_ARB_STATS_EN
  ,
  output logic [N*8-1:0]   _o_stats
`endif
);

  // Pipeline stages; index 0 is stage 1, index DEPTH-1 drives the outputs.
  logic          valid_q [DEPTH];
  logic [TW-1:0] tag_q   [DEPTH];
  logic [3:0]    field_q [DEPTH];

  logic [TW-1:0] ptr_q, ptr_d;
  logic          stall;
  logic          gnt_any;
  logic [TW-1:0] gnt_idx;
  logic [3:0]    gnt_field;
  int unsigned   idx;

  // A full last stage that downstream refuses freezes everything, bubbles included.
  assign stall = valid_q[DEPTH-1] & ~_i_ready;

  // Search starts at the pointer and wraps; the first valid requester wins.
  always_comb begin
    gnt_any      = 1'b0;
    gnt_idx      = '0;
    idx          = 0;
    _o_req_ready = '0;
    if (!stall) begin
      for (int unsigned k = 0; k < N; k++) begin
        idx = (32'(ptr_q) + k) % N;
        if (!gnt_any && _i_req_valid[idx]) begin
          gnt_any = 1'b1;
          gnt_idx = TW'(idx);
        end
      end
    end
    if (gnt_any) begin
      _o_req_ready[gnt_idx] = 1'b1;
    end
  end

  always_comb begin
    gnt_field = 4'h0;
    if (gnt_any) begin
      gnt_field = _i_req_data[32'(gnt_idx) * W + W - 1 -: 4];
    end
  end

  // A grant is always a transfer, since only valid requesters are granted.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_any) begin
      ptr_d = (32'(gnt_idx) == N - 1) ? '0 : gnt_idx + 1'b1;
    end
  end

  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        valid_q[i] <= 1'b0;
        tag_q[i]   <= '0;
        field_q[i] <= '0;
      end
    end else if (!stall) begin
      valid_q[0] <= gnt_any;
      tag_q[0]   <= gnt_idx;
      field_q[0] <= gnt_field;
      for (int i = 1; i < int'(DEPTH); i++) begin
        valid_q[i] <= valid_q[i-1];
        tag_q[i]   <= tag_q[i-1];
        field_q[i] <= field_q[i-1];
      end
    end
  end

  assign _o_valid  = valid_q[DEPTH-1];
  assign _o_result = field_q[DEPTH-1];
  assign _o_tag    = tag_q[DEPTH-1];

`ifdef DELAY_ARB_STATS_EN
  logic [7:0] cnt_q [N];

  // Count completed results per tag, saturating at 255.
  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      for (int i = 0; i < int'(N); i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < int'(N); i++) begin
        if (_o_valid && _i_ready && (32'(_o_tag) == i) && (cnt_q[i] != 8'hff)) begin
          cnt_q[i] <= cnt_q[i] + 8'd1;
        end
      end
    end
  end

  for (genvar g = 0; g < int'(N); g++) begin : g_stats
    assign _o_stats[g*8 +: 8] = cnt_q[g];
  end
`endif

endmodule

// File: tb/tb_e_delay_arbiter.sv
// Directed bench for e_delay_arbiter with N=4, W=16, DEPTH=3.
module tb_e_delay_arbiter;

  localparam int unsigned N     = 4;
  localparam int unsigned W     = 16;
  localparam int unsigned DEPTH = 3;
  localparam int unsigned TW    = 2;

  logic             clk;
  logic             rst_n;
  logic [N-1:0]     req_valid;
  logic [N*W-1:0]   req_data;
  logic [N-1:0]     req_ready;
  logic             o_valid;
  logic [3:0]       o_result;
  logic [TW-1:0]    o_tag;
  logic             ready;
`ifdef DELAY_ARB_STATS_EN
  logic [N*8-1:0]   stats;
`endif

  int n_checks = 0;
  int n_bad    = 0;

  e_delay_arbiter #(
    .N     (N),
    .W     (W),
    .DEPTH (DEPTH)
  ) u_dut (
    ._i_clk       (clk),
    ._i_rst_n     (rst_n),
    ._i_req_valid (req_valid),
    ._i_req_data  (req_data),
    ._o_req_ready (req_ready),
    ._o_valid     (o_valid),
    ._o_result    (o_result),
    ._o_tag       (o_tag),
    ._i_ready     (ready)
`ifdef DELAY_ARB_STATS_EN
    ,
    ._o_stats     (stats)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; leave 1 time unit after it for driving/sampling.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic check_out(input string tag, input logic v, input logic [3:0] r,
                           input logic [TW-1:0] t);
    check({tag, ".valid"}, 32'(o_valid), 32'(v));
    if (v) begin
      check({tag, ".result"}, 32'(o_result), 32'(r));
      check({tag, ".tag"}, 32'(o_tag), 32'(t));
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    req_valid = '0;
    req_data  = '0;
    ready     = 1'b1;
    #1;

    // Reset state.
    check("rst.valid", 32'(o_valid), 0);
    check("rst.result", 32'(o_result), 0);
    check("rst.tag", 32'(o_tag), 0);
    check("rst.ready_none", 32'(req_ready), 0);
`ifdef DELAY_ARB_STATS_EN
    check("rst.stats", stats, 0);
`endif
    req_valid = 4'b0110;
    #1;
    check("rst.ready_p0", 32'(req_ready), 32'h2);
    req_valid = '0;
    do_reset();

    // Single requester: 0x1000 then 0x2000.
    req_valid = 4'b0001;
    req_data  = 64'h0000_0000_0000_1000;
    #1;
    check("single.grant", 32'(req_ready), 32'h1);
    step();                                        // E1 accepts 0x1000
    req_data = 64'h0000_0000_0000_2000;
    step();                                        // E2 accepts 0x2000
    req_valid = '0;
    check_out("single.e2", 1'b0, 4'h0, 2'd0);
    step();                                        // E3
    check_out("single.e3", 1'b1, 4'h1, 2'd0);
    step();
    check_out("single.e4", 1'b1, 4'h2, 2'd0);
    step();
    check_out("single.e5", 1'b0, 4'h0, 2'd0);

    // Round-robin fairness from p=0.
    do_reset();
    req_data  = {16'h8000, 16'h7000, 16'h6000, 16'h5000};
    req_valid = 4'b1111;
    for (int c = 1; c <= 12; c++) begin
      #1;
      check("rr.grant", 32'(req_ready), 32'(1) << ((c - 1) % 4));
      step();
      if (c >= 3) begin
        check_out("rr.out", 1'b1, 4'(((c - 3) % 4) + 5), 2'((c - 3) % 4));
      end
    end
    req_valid = '0;
    repeat (3) step();

    // Pointer wrap: p=0 -> grant req2 -> p=3, then 3, then 0, leaving p=1.
    req_valid = 4'b0100;
    #1;
    check("wrap.g2", 32'(req_ready), 32'h4);
    step();                                        // A
    req_valid = 4'b1001;
    #1;
    check("wrap.g3", 32'(req_ready), 32'h8);
    step();                                        // B
    #1;
    check("wrap.g0", 32'(req_ready), 32'h1);
    step();                                        // C
    req_valid = 4'b1111;
    #1;
    check("wrap.p1", 32'(req_ready), 32'h2);
    req_valid = '0;
    check_out("wrap.c", 1'b1, 4'h7, 2'd2);
    step();
    check_out("wrap.d", 1'b1, 4'h8, 2'd3);
    step();
    check_out("wrap.e", 1'b1, 4'h5, 2'd0);
    step();
    check_out("wrap.f", 1'b0, 4'h0, 2'd0);

    // ready low with an empty pipeline must not stall.
    ready     = 1'b0;
    req_valid = 4'b0001;
    #1;
    check("idle_nostall", 32'(req_ready), 32'h1);
    req_valid = '0;
    ready     = 1'b1;

    // Backpressure.
    do_reset();
    req_valid = 4'b1111;
    repeat (3) step();                             // grants 0,1,2; p=3
    check_out("bp.full", 1'b1, 4'h5, 2'd0);
    ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp.ready0", 32'(req_ready), 0);
      step();
      check_out("bp.hold", 1'b1, 4'h5, 2'd0);
    end
    ready = 1'b1;
    #1;
    check("bp.release_p3", 32'(req_ready), 32'h8);
    req_valid = '0;
    step();
    check_out("bp.d1", 1'b1, 4'h6, 2'd1);
    step();
    check_out("bp.d2", 1'b1, 4'h7, 2'd2);
    step();
    check_out("bp.d3", 1'b0, 4'h0, 2'd0);

    // Async reset with three results in flight (p=3 going in).
    req_valid = 4'b1111;
    repeat (3) step();                             // grants 3,0,1
    check_out("ar.pre", 1'b1, 4'h8, 2'd3);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar.valid", 32'(o_valid), 0);
    check("ar.tag", 32'(o_tag), 0);
    check("ar.result", 32'(o_result), 0);
    check("ar.p0", 32'(req_ready), 32'h1);
    req_valid = '0;
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    req_valid = 4'b0100;
    #1;
    check("ar.grant", 32'(req_ready), 32'h4);
    step();
    req_valid = '0;
    step();
    check_out("ar.e2", 1'b0, 4'h0, 2'd0);
    step();
    check_out("ar.e3", 1'b1, 4'h7, 2'd2);
    step();

`ifdef DELAY_ARB_STATS_EN
    // Saturating stats on req1.
    do_reset();
    req_valid = 4'b0010;
    repeat (300) step();
    req_valid = '0;
    repeat (3) step();
    check("stats.lane1", 32'(stats[15:8]), 255);
    check("stats.lane0", 32'(stats[7:0]), 0);
    check("stats.lane23", 32'(stats[31:16]), 0);
`endif

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule

// File: doc/e_delay_arbiter.md
# e_delay_arbiter

Round-robin arbiter and sequencer that shares one `DEPTH`-stage extract-and-delay pipeline between `N` requesters. Each requester offers a packed `W`-bit word. The block grants at most one requester per cycle and extracts the top 4-bit field of the granted word. That field travels down the pipeline with the requester's index as a tag, and the result is presented on a single valid/ready output port. It sits between the per-lane producers and the shared delay datapath, replacing per-lane pipeline copies.

## Interface
Parameters:
- `N`, 4: number of requesters (2..8).
- `W`, 16: request word width (≥4); the field is bits `[W-1:W-4]`.
- `DEPTH`, 3: pipeline stages (≥1).

Ports (clock and reset first):
- `_i_clk` input 1: single clock, rising edge.
- `_i_rst_n` input 1: reset; asynchronous assert, active-low.
- `_i_req_valid` input N: per-requester valid.
- `_i_req_data` input N*W: requester i occupies bits `[i*W +: W]`.
- `_o_req_ready` input/output: output N, one-hot grant (or zero); a transfer occurs when valid[i] and ready[i] are both high.
- `_o_valid` output 1: result valid.
- `_o_result` output 4: extracted field.
- `_o_tag` output clog2(N) (min 1): index of the originating requester.
- `_i_ready` input 1: downstream accepts the result.
- `_o_stats` output N*8: present only with `DELAY_ARB_STATS_EN`; see Configuration.

## Operation
- Pipeline registers: stages 1..DEPTH, each holding `{valid, tag, field}`. The outputs are driven from stage DEPTH.
- Stall condition: `stall = stage[DEPTH].valid & ~_i_ready`.
- While stalled:
  - All stages hold.
  - `_o_req_ready` is all zero.
  - No pointer update.
- While not stalled, on every edge:
  - Every stage shifts forward by one.
  - Stage 1 loads the granted request, or a bubble (valid=0) if there was no grant.
- Grant: round-robin pointer `p` (reset 0).
  - The grant goes to the first i in the order p, p+1, …, N-1, 0, …, p-1 with `_i_req_valid[i]` high.
  - `_o_req_ready` is combinational from `_i_req_valid`, `p` and `stall`.
- Pointer update: after a transfer from requester g, `p <= (g+1) mod N`; N-1 wraps to 0. With no transfer, p is unchanged.
- Data capture: `field = _i_req_data[g*W + W-1 -: 4]`; `tag = g`. All other bits are ignored.
- Bubbles are not collapsed: a stall freezes the whole pipeline, including empty stages.

## Timing
- Reset value of all outputs:
  - `_o_valid` = 0, `_o_result` = 0, `_o_tag` = 0, `_o_stats` = 0.
  - `_o_req_ready` reflects the requests with p=0 and no stall.
  - All stage valids are 0.
- Reset behaviour:
  - Assertion mid-operation clears every stage, p and the stats immediately, without waiting for a clock edge.
  - In-flight results are dropped.
- Deassertion is synchronized externally; the first grant can occur at the first rising edge after deassertion.
- Latency: a request accepted at edge E appears on the outputs after edge E+DEPTH-1. That is, it is valid in the cycle following DEPTH rising edges, counting E. Each stall cycle adds exactly one cycle.
- Throughput: one result per cycle when there are no stalls. With all N requesters continuously valid, each is granted exactly once every N cycles.
- Output handshake: `_o_valid`, `_o_result` and `_o_tag` hold stable while `_o_valid & ~_i_ready`.
- `_i_ready` high with `_o_valid` low is legal. No stall occurs.

## Configuration
- `DELAY_ARB_STATS_EN` defined:
  - Adds the `_o_stats` port.
  - Per-requester 8-bit counter `[i*8 +: 8]`, incremented when a result tagged i completes (`_o_valid & _i_ready`).
  - Saturates at 255 and never wraps.
  - Cleared by reset.
- `DELAY_ARB_STATS_EN` undefined: the port and counters are absent. Arbitration behaviour is identical in both builds.

## Test plan
- Single requester: reset for 2 cycles, req0 valid with data 0x1000, `_i_ready`=1. Response:
  - `_o_valid`=1, `_o_result`=1 and `_o_tag`=0 after 3 edges.
  - Next request 0x2000 gives result 2 one cycle later.
- Round-robin fairness: all 4 requesters valid continuously, requester i data = (i+5)<<12. Response:
  - Output tags cycle 0,1,2,3,0,… with results 5,6,7,8.
  - Each requester's ready is high exactly 1 cycle in 4.
- Pointer wrap: p=3 with only req3 and req0 valid. Response:
  - Grant goes to 3, then to 0.
  - Next p=1.
- Backpressure:
  - Fill the pipeline, then hold `_i_ready`=0 for 5 cycles. All `_o_req_ready`=0, and the outputs are frozen on the same tag/result.
  - Release: the results drain in order with no loss or duplication.
- Async reset mid-flight: assert `_i_rst_n`=0 between edges with 3 results in flight. Response:
  - `_o_valid` drops to 0 immediately.
  - After release, the first new request returns after 3 edges, and p=0.
- Stats (with `DELAY_ARB_STATS_EN`): 300 completions from req1 gives `_o_stats[15:8]`=255. Other lanes stay at 0.
